// File: rtl/param_bounded_counter_if.sv
// Handshake/bus bundle for param_bounded_counter: controls and bounds in,
// counter state and monitor flags out.
interface param_bounded_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] lo_bound;
    logic [WIDTH-1:0] hi_bound;
    logic [1:0]       mode;

    logic [WIDTH-1:0] count;
    logic             dir;
    logic             at_hi;
    logic             at_lo;
    logic             wrap_pulse;
    logic             bound_err;
    logic             reach_done;
    logic             reach_timeout;

    modport master (
        output en, clear, load, load_val, lo_bound, hi_bound, mode,
        input  count, dir, at_hi, at_lo, wrap_pulse, bound_err,
               reach_done, reach_timeout
    );

    modport slave (
        input  en, clear, load, load_val, lo_bound, hi_bound, mode,
        output count, dir, at_hi, at_lo, wrap_pulse, bound_err,
               reach_done, reach_timeout
    );
endinterface

// File: rtl/param_bounded_counter.sv
// Bounded up/down/saturate/bounce counter with a reach monitor that flags
// whether hi_bound was reached within REACH_LIMIT enabled cycles.
module param_bounded_counter #(
    parameter int WIDTH       = 4,
    parameter int REACH_LIMIT = 10
) (
    input logic clk,
    input logic reset,
    param_bounded_counter_if.slave bus
);
    localparam int RW = $clog2(REACH_LIMIT + 1);
    localparam logic [RW-1:0] LIMIT = RW'(REACH_LIMIT);

    typedef enum logic [1:0] {
        M_WRAP_UP   = 2'b00,
        M_WRAP_DOWN = 2'b01,
        M_SAT_UP    = 2'b10,
        M_BOUNCE    = 2'b11
    } mode_t;

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             dir_q, dir_nxt;
    logic             wrap_q, wrap_nxt;
    logic [RW-1:0]    reach_cnt_q;
    logic             done_q, timeout_q;

    logic [WIDTH-1:0] lo, hi, clamp_val, restart_val;
    logic             bound_err, in_range, eff_dir;
    mode_t            mode;

    assign lo        = bus.lo_bound;
    assign hi        = bus.hi_bound;
    assign mode      = mode_t'(bus.mode);
    assign bound_err = lo > hi;
    assign in_range  = (count_q >= lo) && (count_q <= hi);

    // Modes 00/10 force counting up and 01 down; bounce keeps its own direction.
    always_comb begin
        eff_dir = 1'b1;
        case (mode)
            M_WRAP_DOWN: eff_dir = 1'b0;
            M_BOUNCE:    eff_dir = dir_q;
            default:     eff_dir = 1'b1;
        endcase
    end

    assign restart_val = (mode == M_WRAP_DOWN) ? hi : lo;

    always_comb begin
        clamp_val = bus.load_val;
        if (bus.load_val < lo)
            clamp_val = lo;
        else if (bus.load_val > hi)
            clamp_val = hi;
    end

    always_comb begin
        count_nxt = count_q;
        dir_nxt   = dir_q;
        wrap_nxt  = 1'b0;
        if (!bound_err) begin
            if (bus.clear) begin
                count_nxt = restart_val;
                dir_nxt   = (mode != M_WRAP_DOWN);
            end else if (bus.load) begin
                count_nxt = clamp_val;
            end else begin
                dir_nxt = eff_dir;
                if (bus.en) begin
                    if (!in_range) begin
                        count_nxt = restart_val;
                    end else begin
                        case (mode)
                            M_WRAP_UP: begin
                                if (count_q == hi) begin
                                    count_nxt = lo;
                                    wrap_nxt  = 1'b1;
                                end else begin
                                    count_nxt = count_q + 1'b1;
                                end
                            end
                            M_WRAP_DOWN: begin
                                if (count_q == lo) begin
                                    count_nxt = hi;
                                    wrap_nxt  = 1'b1;
                                end else begin
                                    count_nxt = count_q - 1'b1;
                                end
                            end
                            M_SAT_UP: begin
                                if (count_q != hi)
                                    count_nxt = count_q + 1'b1;
                            end
                            M_BOUNCE: begin
                                // A zero-width window has nowhere to bounce to.
                                if (lo == hi) begin
                                    count_nxt = count_q;
                                end else if (eff_dir && count_q == hi) begin
                                    count_nxt = hi - 1'b1;
                                    dir_nxt   = 1'b0;
                                end else if (!eff_dir && count_q == lo) begin
                                    count_nxt = lo + 1'b1;
                                    dir_nxt   = 1'b1;
                                end else if (eff_dir) begin
                                    count_nxt = count_q + 1'b1;
                                end else begin
                                    count_nxt = count_q - 1'b1;
                                end
                            end
                            default: count_nxt = count_q;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            dir_q   <= dir_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    // Reach monitor: done wins over timeout when both would fire together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reach_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (!bound_err) begin
            if (bus.clear) begin
                reach_cnt_q <= '0;
                done_q      <= 1'b0;
                timeout_q   <= 1'b0;
            end else if (!done_q && !timeout_q) begin
                if (bus.en && reach_cnt_q != LIMIT)
                    reach_cnt_q <= reach_cnt_q + 1'b1;
                if (count_q == hi)
                    done_q <= 1'b1;
                else if (reach_cnt_q == LIMIT)
                    timeout_q <= 1'b1;
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.dir           = dir_q;
    assign bus.at_hi         = (count_q == hi);
    assign bus.at_lo         = (count_q == lo);
    assign bus.wrap_pulse    = wrap_q;
    assign bus.bound_err     = bound_err;
    assign bus.reach_done    = done_q;
    assign bus.reach_timeout = timeout_q;
endmodule

// File: tb/tb_param_bounded_counter.sv
// Directed-vector bench for param_bounded_counter (WIDTH=4, REACH_LIMIT=10).
module tb_param_bounded_counter;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    param_bounded_counter_if #(.WIDTH(4)) bus ();

    param_bounded_counter #(.WIDTH(4), .REACH_LIMIT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic clr, input logic ld,
                         input logic [3:0] lv);
        bus.en       = en;
        bus.clear    = clr;
        bus.load     = ld;
        bus.load_val = lv;
    endtask

    task automatic set_bounds(input logic [3:0] lo, input logic [3:0] hi, input logic [1:0] m);
        bus.lo_bound = lo;
        bus.hi_bound = hi;
        bus.mode     = m;
    endtask

    int exp_b[8]  = '{2, 3, 4, 5, 4, 3, 2, 3};
    int exp_bd[8] = '{1, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        set_bounds(4'd0, 4'd10, 2'b00);
        #12;
        chk("rst_count", bus.count, 0);
        chk("rst_dir", bus.dir, 1);
        chk("rst_wrap", bus.wrap_pulse, 0);
        chk("rst_done", bus.reach_done, 0);
        chk("rst_tmo", bus.reach_timeout, 0);

        // Wrap-up 0..10 then 0, reach_done one cycle after count=10.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("wu_count", bus.count, k % 11);
            chk("wu_wrap", bus.wrap_pulse, (k == 11));
            chk("wu_done", bus.reach_done, (k >= 11));
            chk("wu_tmo", bus.reach_timeout, 0);
            if (k == 10) chk("wu_at_hi", bus.at_hi, 1);
        end

        // Bounce 2..5 with direction flips.
        set_bounds(4'd2, 4'd5, 2'b11);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("bn_clr_count", bus.count, 2);
        chk("bn_clr_dir", bus.dir, 1);
        chk("bn_clr_done", bus.reach_done, 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("bn_count", bus.count, exp_b[k]);
            chk("bn_dir", bus.dir, exp_bd[k]);
            chk("bn_wrap", bus.wrap_pulse, 0);
        end

        // Reach timeout: periodic load of 0 keeps count from reaching 10.
        set_bounds(4'd0, 4'd10, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, (i % 3 == 2), 4'd0);
            tick();
        end
        chk("to_count", bus.count, 0);
        chk("to_tmo", bus.reach_timeout, 1);
        chk("to_done", bus.reach_done, 0);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        chk("to_clr_tmo", bus.reach_timeout, 0);
        chk("to_clr_done", bus.reach_done, 0);

        // Load clamping and bound_err freeze.
        set_bounds(4'd3, 4'd12, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 4'd15);
        tick();
        chk("ld_clamp_hi", bus.count, 12);
        drive(1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        chk("ld_clamp_lo", bus.count, 3);
        set_bounds(4'd9, 4'd4, 2'b00);
        drive(1'b1, 1'b0, 1'b1, 4'd6);
        #1;
        chk("be_flag", bus.bound_err, 1);
        tick();
        chk("be_hold_ld", bus.count, 3);
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        chk("be_hold_clr", bus.count, 3);
        chk("be_wrap", bus.wrap_pulse, 0);

        // Saturate-up holds at hi.
        set_bounds(4'd0, 4'd3, 2'b10);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_count", bus.count, (k > 3) ? 3 : k);
            chk("sat_wrap", bus.wrap_pulse, 0);
        end

        // lo==hi in wrap-up: count holds, wrap still pulses.
        set_bounds(4'd5, 4'd5, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("eq_count", bus.count, 5);
        chk("eq_wrap", bus.wrap_pulse, 1);
        chk("eq_at_lo", bus.at_lo, 1);

        // clear beats load in wrap-down; async reset mid-run; restart after.
        set_bounds(4'd1, 4'd7, 2'b01);
        drive(1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        chk("wd_clr_count", bus.count, 7);
        chk("wd_clr_dir", bus.dir, 0);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("wd_step", bus.count, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_dir", bus.dir, 1);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_count", bus.count, 7);
        chk("post_rst_wrap", bus.wrap_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/param_bounded_counter.md
PARAM_BOUNDED_COUNTER -- requirements
Module: param_bounded_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 Parameter REACH_LIMIT, default 10, max enabled cycles allowed for count to first reach hi_bound (1..65535).
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count-step enable.
REQ-006 clear  input  1  synchronous restart of count and reach monitor.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 lo_bound  input  WIDTH  lower bound, unsigned, inclusive.
REQ-010 hi_bound  input  WIDTH  upper bound, unsigned, inclusive.
REQ-011 mode  input  2  00 wrap-up, 01 wrap-down, 10 saturate-up, 11 bounce.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 dir  output  1  registered direction, 1 = up.
REQ-014 at_hi / at_lo  output  1 each  combinational count==hi_bound / count==lo_bound.
REQ-015 wrap_pulse  output  1  registered, high one cycle after a wrap step.
REQ-016 bound_err  output  1  combinational lo_bound > hi_bound.
REQ-017 reach_done  output  1  registered sticky: count equalled hi_bound since last reset/clear.
REQ-018 reach_timeout  output  1  registered sticky: REACH_LIMIT enabled cycles elapsed without reach_done.

Function
REQ-019 Priority per cycle SHALL be: clear > load > en step > hold.
REQ-020 While bound_err=1, count and dir SHALL hold regardless of clear/load/en; wrap_pulse SHALL be 0; the reach monitor SHALL freeze.
REQ-021 clear SHALL set count to hi_bound in mode 01, else lo_bound; set dir to 0 in mode 01, else 1; zero the reach cycle counter, reach_done and reach_timeout.
REQ-022 load SHALL set count to load_val clamped to [lo_bound, hi_bound]; dir unchanged.
REQ-023 An en step with count outside [lo_bound, hi_bound] SHALL set count to hi_bound in mode 01, else lo_bound, with no wrap_pulse.
REQ-024 Mode 00: count+1 per step; at hi_bound next value is lo_bound and wrap_pulse=1 next cycle.
REQ-025 Mode 01: count-1 per step; at lo_bound next value is hi_bound and wrap_pulse=1 next cycle.
REQ-026 Mode 10: count+1 per step; at hi_bound count holds; wrap_pulse never asserts.
REQ-027 Mode 11: step in direction dir; at hi_bound with dir=1, next count hi_bound-1 and dir=0; at lo_bound with dir=0, next count lo_bound+1 and dir=1; no wrap_pulse.
REQ-028 When lo_bound==hi_bound, every mode SHALL hold count at the bound; wraps in modes 00/01 still pulse wrap_pulse.
REQ-029 A mode change SHALL take effect on the next step; entering modes 00/10 forces dir=1, entering 01 forces dir=0, entering 11 keeps dir.
REQ-030 Arithmetic SHALL be WIDTH-bit unsigned; no step may overflow past 2^WIDTH-1 or underflow below 0.
REQ-031 Reach monitor: counts cycles with en=1 while reach_done=0 and reach_timeout=0; reach_done sets the cycle after count==hi_bound is registered; reach_timeout sets when the counter hits REACH_LIMIT with reach_done=0; the two are mutually exclusive.
REQ-032 Reach counter width SHALL be clog2(REACH_LIMIT+1) and SHALL saturate, never wrap.

Reset
REQ-033 reset=1 SHALL immediately force count=0, dir=1, wrap_pulse=0, reach_done=0, reach_timeout=0, reach counter=0.
REQ-034 Reset assertion mid-operation SHALL abort any step; first step after deassertion follows REQ-023 if 0 is outside bounds.

Verification
REQ-035 WIDTH=4, lo=0, hi=10, mode 00, en=1 from reset release -> count 0..10, then 0; wrap_pulse one cycle after count=10; reach_done set at cycle 11, reach_timeout stays 0.
REQ-036 lo=2, hi=5, mode 11, en=1 after clear -> count 2,3,4,5,4,3,2,3; dir flips at 5 and 2.
REQ-037 lo=0, hi=10, REACH_LIMIT=10, en=1, load=1 with load_val=0 every 3rd cycle -> reach_timeout=1 after 10 enabled cycles, reach_done=0; clear zeroes both.
REQ-038 lo=3, hi=12, load_val=15 -> count=12; load_val=1 -> count=3; lo=9, hi=4 -> bound_err=1, count frozen.
REQ-039 clear and load both high, mode 01, lo=1, hi=7 -> count=7, dir=0; reset asserted mid-run -> count=0 same time step, next en step -> count=7.
